// File: rtl/fifo_stream_drain.sv
// Drains a sync_fifo read port into a valid/ready stream with burst framing.
// A 3-entry skid buffer absorbs the FIFO read latency so reads never depend on m_ready.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int BEAT_BITS  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  idle
);

    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic [BEAT_BITS-1:0]  beat;
    logic [2:0]            credit_used;
    logic                  landing;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A word already in flight still needs a slot, so it counts against the credit.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en  = rst_n && en && !fifo_empty && (credit_used < 3'd3);

    assign landing = inflight;
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat == BEAT_BITS'(BURST_LEN - 1));
    assign idle    = (occ == 2'd0) && !inflight && fifo_empty;

    always_comb begin
        m_data = buf_q[0];
        case (rd_ptr)
            2'd1:    m_data = buf_q[1];
            2'd2:    m_data = buf_q[2];
            default: m_data = buf_q[0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            beat     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            for (int i = 0; i < 3; i++) begin
                if (landing && (wr_ptr == 2'(i))) begin
                    buf_q[i] <= fifo_rd_data;
                end
            end
            if (landing) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                beat   <= (beat == BEAT_BITS'(BURST_LEN - 1)) ? '0 : beat + 1'b1;
            end
            if (landing && !pop) begin
                occ <= occ + 2'd1;
            end else if (!landing && pop) begin
                occ <= occ - 2'd1;
            end
        end
    end

    // A landing into a full buffer with no pop would overflow the occupancy.
    assert property (@(posedge clk) disable iff (!rst_n) !((occ == 2'd3) && landing && !pop));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural 16-deep sync_fifo model
// and a handshake log that all checks are made against.
module tb_fifo_stream_drain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_rst_n;
    logic       en;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       idle;

    always #5 clk = ~clk;

    fifo_stream_drain #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .idle         (idle)
    );

    // Behavioural sync_fifo: registered read data, one cycle after rd_en.
    logic [7:0] fmem [16];
    logic [3:0] fwp, frp;
    logic [4:0] fcount;
    logic       underflow_seen;
    logic       push_en;
    logic [7:0] push_data;

    assign fifo_empty = (fcount == 5'd0);

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            fwp            <= 4'd0;
            frp            <= 4'd0;
            fcount         <= 5'd0;
            fifo_rd_data   <= 8'd0;
            underflow_seen <= 1'b0;
        end else begin
            if (push_en) begin
                fmem[fwp] <= push_data;
                fwp       <= fwp + 4'd1;
            end
            if (fifo_rd_en) begin
                if (fcount == 5'd0) begin
                    underflow_seen <= 1'b1;
                end else begin
                    fifo_rd_data <= fmem[frp];
                    frp          <= frp + 4'd1;
                end
            end
            fcount <= fcount + (push_en ? 5'd1 : 5'd0)
                             - ((fifo_rd_en && fcount != 5'd0) ? 5'd1 : 5'd0);
        end
    end

    int         total = 0;
    int         bad   = 0;
    int         cyc;
    int         total_rd;
    int         hs_total;
    int         max_occ;
    int         occ_model;
    logic       prev_rd;
    logic [7:0] push_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc [$];
    int         rd_cyc [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at the falling edge, then sample the settled outputs.
    task automatic applyStimulus(input logic e, input logic r);
        @(negedge clk);
        en      = e;
        m_ready = r;
        if (push_q.size() > 0 && fcount < 5'd16) begin
            push_en   = 1'b1;
            push_data = push_q.pop_front();
        end else begin
            push_en = 1'b0;
        end
        #1;
        occ_model = (total_rd - (prev_rd ? 1 : 0)) - hs_total;
        if (occ_model > max_occ) max_occ = occ_model;
        if (fifo_rd_en) begin
            rd_cyc.push_back(cyc);
            total_rd++;
        end
        prev_rd = fifo_rd_en;
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_last.push_back(m_last);
            rx_cyc.push_back(cyc);
            hs_total++;
        end
        cyc++;
    endtask

    task automatic clearLog();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        rd_cyc.delete();
        total_rd = 0;
        hs_total = 0;
        prev_rd  = 1'b0;
        max_occ  = 0;
        cyc      = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n      = 1'b0;
        fifo_rst_n = 1'b0;
        en         = 1'b0;
        m_ready    = 1'b0;
        push_en    = 1'b0;
        push_q.delete();
        @(negedge clk);
        rst_n      = 1'b1;
        fifo_rst_n = 1'b1;
        clearLog();
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) push_q.push_back(base + 8'(i));
        while (push_q.size() > 0) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        clearLog();
    endtask

    task automatic drain(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_data.size() < n && k < budget) begin
            applyStimulus(1'b1, 1'b1);
            k++;
        end
        checkOutput({tag, "_count"}, rx_data.size(), n);
    endtask

    task automatic checkStream(input string tag, input logic [7:0] base, input int n);
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), rx_data[i], base + 8'(i));
            checkOutput($sformatf("%s_last%0d", tag, i), rx_last[i], (i % 4) == 3);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stable_bad;
        rst_n = 1'b1; fifo_rst_n = 1'b1; en = 1'b0; m_ready = 1'b0;
        push_en = 1'b0; push_data = 8'd0;
        clearLog();
        #1;
        rst_n = 1'b0; fifo_rst_n = 1'b0;
        @(negedge clk);
        fifo_rst_n = 1'b1;

        // Reset held on the drain while its FIFO is loaded.
        for (int i = 0; i < 4; i++) push_q.push_back(8'h55 + 8'(i));
        repeat (6) applyStimulus(1'b1, 1'b1);
        checkOutput("rst_fcount", fcount, 4);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_idle_loaded", idle, 0);
        doReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_idle_empty", idle, 1);

        // Full-rate drain.
        doReset();
        preload(8'h00, 16);
        drain("full", 16, 60);
        checkOutput("full_first_rd", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 0);
        checkOutput("full_latency", (rx_cyc.size() > 0) ? rx_cyc[0] : -1, 2);
        checkOutput("full_span", (rx_cyc.size() == 16) ? rx_cyc[15] - rx_cyc[0] : -1, 15);
        checkStream("full", 8'h00, 16);
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkOutput("full_underflow", underflow_seen, 0);
        checkOutput("full_idle", idle, 1);

        // Backpressure: three credits, then hold.
        doReset();
        preload(8'h00, 16);
        stable_bad = 0;
        repeat (10) begin
            applyStimulus(1'b1, 1'b0);
            if (m_valid && (m_data !== 8'h00 || m_last !== 1'b0)) stable_bad++;
        end
        checkOutput("bp_reads", rd_cyc.size(), 3);
        checkOutput("bp_fcount", fcount, 13);
        checkOutput("bp_m_valid", m_valid, 1);
        checkOutput("bp_m_data", m_data, 0);
        checkOutput("bp_stable", stable_bad, 0);
        drain("bp", 16, 60);
        checkOutput("bp_span_ok", (rx_cyc.size() == 16) && (rx_cyc[15] - rx_cyc[0] <= 16), 1);
        checkStream("bp", 8'h00, 16);

        // Random m_ready over 64 words with continuous refill.
        doReset();
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            push_q.push_back(w);
        end
        begin
            int k = 0;
            while (rx_data.size() < 64 && k < 2000) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)));
                k++;
            end
        end
        checkOutput("rnd_count", rx_data.size(), 64);
        for (int i = 0; i < 64 && i < rx_data.size(); i++) begin
            checkOutput($sformatf("rnd_data%0d", i), rx_data[i], exp_q[i]);
            checkOutput($sformatf("rnd_last%0d", i), rx_last[i], (i % 4) == 3);
        end
        checkOutput("rnd_max_occ_ok", max_occ <= 3, 1);
        checkOutput("rnd_underflow", underflow_seen, 0);

        // en dropped in the cycle a read is issued.
        doReset();
        preload(8'h20, 8);
        applyStimulus(1'b1, 1'b1);
        checkOutput("en_rd_pulse", fifo_rd_en, 1);
        repeat (8) applyStimulus(1'b0, 1'b1);
        checkOutput("en_rx_count", rx_data.size(), 1);
        checkOutput("en_rx_word", (rx_data.size() > 0) ? rx_data[0] : 8'hFF, 8'h20);
        checkOutput("en_reads", rd_cyc.size(), 1);
        checkOutput("en_fcount", fcount, 7);
        drain("en", 8, 40);
        checkStream("en", 8'h20, 8);

        // Reset in the middle of a burst realigns the beat counter.
        doReset();
        preload(8'h10, 8);
        begin
            int k = 0;
            while (rx_data.size() < 3 && k < 20) begin
                applyStimulus(1'b1, 1'b1);
                k++;
            end
        end
        checkOutput("mid_pre_count", rx_data.size(), 3);
        doReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_m_valid", m_valid, 0);
        preload(8'hA0, 8);
        drain("mid", 8, 40);
        checkStream("mid", 8'hA0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
